// File: rtl/square_pkg.sv
// square_pkg: shared coordinate width and FSM state type for the square drawer/sampler pair
package square_pkg;
  localparam int COORD_W = 11;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_e;
endpackage

// File: rtl/square_scan_counter.sv
// square_scan_counter: row-major dx/dy offset walker over an inclusive (SIZE+1)x(SIZE+1) square
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   load_i          restart at offset (0,0)
//   step_i          advance one pixel (dx wraps to 0 at SIZE and bumps dy)
//   dx_o, dy_o      current offsets
//   last_o          current offset is the final corner (SIZE,SIZE)
module square_scan_counter #(
  parameter int SIZE = 10,
  parameter int W = (SIZE < 1) ? 1 : $clog2(SIZE + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         step_i,
  output logic [W-1:0] dx_o,
  output logic [W-1:0] dy_o,
  output logic         last_o
);
  logic [W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic row_end;
  assign row_end = dx_q == W'(SIZE);
  assign last_o = row_end && dy_q == W'(SIZE);
  assign dx_o = dx_q;
  assign dy_o = dy_q;
  always_comb begin
    dx_d = load_i ? '0 : step_i ? (row_end ? '0 : dx_q + 1'b1) : dx_q;
    dy_d = load_i ? '0 : (step_i && row_end) ? dy_q + 1'b1 : dy_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end
endmodule

// File: rtl/square_sampler.sv
// square_sampler: scans a square of framebuffer pixels and counts the lit ones
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, x0, y0         scan request and top-left corner (latched when accepted in IDLE)
//   rd_en, rd_x, rd_y     one framebuffer read request per cycle while scanning
//   rd_data               pixel value, valid RD_LAT cycles after its rd_en
//   busy                  scan in progress (through the done cycle)
//   count, hit            lit-pixel count of the last completed scan and count != 0
//   done                  one-cycle pulse, count/hit final in the same cycle
// Optional: define SQUARE_SAMPLER_EARLY_EXIT_EN to stop issuing reads at the first lit return.
module square_sampler
  import square_pkg::*;
#(
  parameter int SIZE = 10,
  parameter int RD_LAT = 1,
  parameter int CNT_W = $clog2((SIZE + 1) * (SIZE + 1) + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  output logic               rd_en,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  input  logic               rd_data,
  output logic               busy,
  output logic [CNT_W-1:0]   count,
  output logic               hit,
  output logic               done
);
  localparam int OFF_W = (SIZE < 1) ? 1 : $clog2(SIZE + 1);
  // every pipeline stage except the one returning this cycle
  localparam logic [RD_LAT-1:0] PEND_MASK = {RD_LAT{1'b1}} >> 1;
  state_e state_q, state_d;
  logic [COORD_W-1:0] x0_q, y0_q;
  logic [OFF_W-1:0] dx, dy;
  logic [RD_LAT-1:0] vld_q;
  logic [CNT_W-1:0] acc_q, count_q;
  logic hit_q, done_q, last, accept, ret_lit, pend, stop;
  assign accept = state_q == IDLE && start;
  assign rd_en = state_q == SCAN;
  assign rd_x = x0_q + COORD_W'(dx);
  assign rd_y = y0_q + COORD_W'(dy);
  assign ret_lit = vld_q[RD_LAT-1] && rd_data;
  assign pend = |(vld_q & PEND_MASK);
  assign busy = state_q != IDLE || done_q;
  assign count = count_q;
  assign hit = hit_q;
  assign done = done_q;
`ifdef SQUARE_SAMPLER_EARLY_EXIT_EN
  assign stop = last || ret_lit;
`else
  assign stop = last;
`endif
  square_scan_counter #(.SIZE(SIZE), .W(OFF_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept),
    .step_i (rd_en && !last),
    .dx_o   (dx),
    .dy_o   (dy),
    .last_o (last)
  );
  always_comb begin
    state_d = state_q == IDLE  ? (start ? SCAN : IDLE)
            : state_q == SCAN  ? (stop ? DRAIN : SCAN)
            : state_q == DRAIN ? (pend ? DRAIN : FINISH)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      vld_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= RD_LAT'({vld_q, rd_en});
      acc_q   <= accept ? '0 : acc_q + CNT_W'(ret_lit);
      done_q  <= state_q == FINISH;
      if (accept) begin
        x0_q <= x0;
        y0_q <= y0;
      end
      if (state_q == FINISH) begin
        count_q <= acc_q;
        hit_q   <= acc_q != '0;
      end
    end
  end
endmodule

// File: tb/tb_square_sampler.sv
// tb_square_sampler: directed checks of square_sampler at RD_LAT=1 (u_a) and RD_LAT=3 (u_b), SIZE=2
module tb_square_sampler;
  logic clk = 1'b0, rst = 1'b1, a_start = 1'b0, b_start = 1'b0;
  logic [10:0] x0 = '0, y0 = '0;
  logic a_rd_en, b_rd_en, a_rd_data, b_rd_data, a_busy, b_busy, a_hit, b_hit, a_done, b_done;
  logic [10:0] a_rd_x, a_rd_y, b_rd_x, b_rd_y;
  logic [3:0] a_count, b_count;
  logic a_pipe = 1'b0;
  logic [2:0] b_pipe = '0;
  int mode = 0, cyc = 0, n_vec = 0, n_err = 0;
  int a_n, b_n, a_first, b_first, a_nd, b_nd, a_dcyc, b_dcyc;
  int a_xs[16], a_ys[16];
`ifdef SQUARE_SAMPLER_EARLY_EXIT_EN
  localparam int M1_N = 6, M1_CNT = 1, ALL_N = 4, ALL_CNT = 4, ALL_LAT = 8, M3_N = 2, M3_LAT = 4;
`else
  localparam int M1_N = 9, M1_CNT = 2, ALL_N = 9, ALL_CNT = 9, ALL_LAT = 13, M3_N = 9, M3_LAT = 11;
`endif

  always #5 clk = ~clk;

  square_sampler #(.SIZE(2), .RD_LAT(1)) u_a (
    .clk(clk), .reset(rst), .start(a_start), .x0(x0), .y0(y0),
    .rd_en(a_rd_en), .rd_x(a_rd_x), .rd_y(a_rd_y), .rd_data(a_rd_data),
    .busy(a_busy), .count(a_count), .hit(a_hit), .done(a_done)
  );
  square_sampler #(.SIZE(2), .RD_LAT(3)) u_b (
    .clk(clk), .reset(rst), .start(b_start), .x0(x0), .y0(y0),
    .rd_en(b_rd_en), .rd_x(b_rd_x), .rd_y(b_rd_y), .rd_data(b_rd_data),
    .busy(b_busy), .count(b_count), .hit(b_hit), .done(b_done)
  );

  function automatic logic lit(input logic [10:0] x, input logic [10:0] y);
    case (mode)
      1: return (x == 21 && y == 21) || (x == 22 && y == 22);
      2: return 1'b1;
      3: return x == 20 && y == 20;
      default: return 1'b0;
    endcase
  endfunction

  // framebuffer model with fixed read latency per instance
  always @(posedge clk) begin
    a_pipe <= a_rd_en && lit(a_rd_x, a_rd_y);
    b_pipe <= {b_pipe[1:0], b_rd_en && lit(b_rd_x, b_rd_y)};
  end
  assign a_rd_data = a_pipe;
  assign b_rd_data = b_pipe[2];

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (a_rd_en) begin
      if (a_n == 0) a_first = cyc;
      if (a_n < 16) begin
        a_xs[a_n] = int'(a_rd_x);
        a_ys[a_n] = int'(a_rd_y);
      end
      a_n++;
    end
    if (b_rd_en) begin
      if (b_n == 0) b_first = cyc;
      b_n++;
    end
    if (a_done) begin
      a_nd++;
      a_dcyc = cyc;
    end
    if (b_done) begin
      b_nd++;
      b_dcyc = cyc;
    end
  endtask

  task automatic clr();
    a_n = 0; b_n = 0; a_first = 0; b_first = 0;
    a_nd = 0; b_nd = 0; a_dcyc = 0; b_dcyc = 0;
  endtask

  task automatic go(input bit use_b, input int x, input int y, input int m);
    mode = m;
    x0 = 11'(x);
    y0 = 11'(y);
    clr();
    if (use_b) b_start = 1'b1;
    else a_start = 1'b1;
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
    x0 = 11'd777;
    y0 = 11'd777;
    repeat (30) tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_rd_en", a_rd_en, 0);
    check("rst_rd_x", a_rd_x, 0);
    check("rst_rd_y", a_rd_y, 0);
    check("rst_busy", a_busy, 0);
    check("rst_count", a_count, 0);
    check("rst_hit", a_hit, 0);
    check("rst_done", a_done, 0);
    rst = 1'b0;
    tick();

    go(0, 20, 20, 0);
    check("empty_reads", a_n, 9);
    for (int i = 0; i < 9; i++) begin
      check("empty_x", a_xs[i], 20 + i % 3);
      check("empty_y", a_ys[i], 20 + i / 3);
    end
    check("empty_lat", a_dcyc - a_first, 11);
    check("empty_dones", a_nd, 1);
    check("empty_count", a_count, 0);
    check("empty_hit", a_hit, 0);

    go(1, 20, 20, 0);
    check("b_empty_reads", b_n, 9);
    check("b_empty_lat", b_dcyc - b_first, 13);

    go(0, 20, 20, 1);
    check("lit2_reads", a_n, M1_N);
    check("lit2_count", a_count, M1_CNT);
    check("lit2_hit", a_hit, 1);

    clr();
    mode = 1;
    x0 = 11'd20;
    y0 = 11'd20;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("midrst_reads", a_n, 3);
    check("midrst_rd_en", a_rd_en, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_count", a_count, 0);
    check("midrst_done", a_done, 0);
    rst = 1'b0;
    tick();

    go(0, 20, 20, 1);
    check("after_rst_reads", a_n, M1_N);
    check("after_rst_x0", a_xs[0], 20);
    check("after_rst_dones", a_nd, 1);
    check("after_rst_count", a_count, M1_CNT);

    clr();
    mode = 0;
    x0 = 11'd0;
    y0 = 11'd0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (4) tick();
    check("hold_count", a_count, M1_CNT);
    check("hold_hit", a_hit, 1);
    check("hold_busy", a_busy, 1);
    repeat (26) tick();
    check("new_count", a_count, 0);
    check("new_hit", a_hit, 0);
    check("new_dones", a_nd, 1);

    go(1, 20, 20, 2);
    check("all_reads", b_n, ALL_N);
    check("all_count", b_count, ALL_CNT);
    check("all_hit", b_hit, 1);
    check("all_lat", b_dcyc - b_first, ALL_LAT);

    clr();
    mode = 0;
    x0 = 11'd20;
    y0 = 11'd20;
    a_start = 1'b1;
    tick();
    for (int i = 1; i <= 28; i++) begin
      a_start = (i == 3 || i == 10);
      tick();
    end
    a_start = 1'b0;
    check("busy_start_reads", a_n, 9);
    check("busy_start_dones", a_nd, 1);

    go(0, 2046, 5, 0);
    check("wrap_reads", a_n, 9);
    for (int i = 0; i < 9; i++) begin
      check("wrap_x", a_xs[i], (2046 + i % 3) % 2048);
      check("wrap_y", a_ys[i], 5 + i / 3);
    end
    check("wrap_lat", a_dcyc - a_first, 11);

    go(0, 20, 20, 3);
    check("corner_reads", a_n, M3_N);
    check("corner_lat", a_dcyc - a_first, M3_LAT);
    check("corner_hit", a_hit, 1);
    check("corner_count", a_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/square_sampler.md
Name: square_sampler

Overview:
Reader counterpart to the square-drawing engine. On start it scans the inclusive square x0..x0+SIZE, y0..y0+SIZE, row-major, issuing one framebuffer read per cycle. It counts lit pixels returned by the framebuffer read port and reports the count plus a hit flag. Sits beside the drawer on the framebuffer for collision/occupancy checks before or after a draw.

Parameters:
SIZE, 10, square extent; scan covers (SIZE+1)x(SIZE+1) pixels, matching the drawer's inclusive corner
RD_LAT, 1, fixed framebuffer read latency in cycles (>=1); rd_data for a request is valid exactly RD_LAT cycles after rd_en
CNT_W, $clog2((SIZE+1)*(SIZE+1)+1), count width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request a scan; sampled only in IDLE
x0  in  11  top-left x, latched on accepted start
y0  in  11  top-left y, latched on accepted start
rd_en  out  1  read request strobe, one pixel per cycle
rd_x  out  11  read x coordinate
rd_y  out  11  read y coordinate
rd_data  in  1  pixel value, valid RD_LAT cycles after its rd_en
busy  out  1  high from cycle after accepted start through the done cycle
count  out  CNT_W  number of lit pixels in last completed scan
hit  out  1  count != 0, registered with count
done  out  1  one-cycle pulse; count/hit final in same cycle

Behaviour:
- Reset: state IDLE; rd_en=0, rd_x=0, rd_y=0, busy=0, count=0, hit=0, done=0; read pipeline valid bits cleared.
- States: IDLE, SCAN, DRAIN, FINISH.
- IDLE: start=1 -> latch x0/y0, clear offsets dx=dy=0, clear accumulator, -> SCAN. start=0 -> stay.
- SCAN: rd_en=1, rd_x=x0_l+dx, rd_y=y0_l+dy, registered outputs. Each cycle dx++; at dx==SIZE: dx=0, dy++. At dx==SIZE and dy==SIZE, that is the last request -> DRAIN. Exactly (SIZE+1)^2 consecutive rd_en cycles, no gaps.
- Read return: RD_LAT-deep shift of rd_en; when delayed valid=1 and rd_data=1, accumulator++.
- DRAIN: rd_en=0; hold RD_LAT cycles until last return accumulated -> FINISH.
- FINISH: count<=accumulator, hit<=(accumulator!=0), done=1 for this single cycle, busy=1; -> IDLE unconditionally.
- Latency: first rd_en the cycle after start is sampled. done asserts (SIZE+1)^2+RD_LAT+1 cycles after the first rd_en cycle begins. For SIZE=2, RD_LAT=1: done 11 cycles after first rd_en.
- count/hit hold the previous result through a new scan. They update only in FINISH.
- start while busy: ignored, with no queuing. start held high through FINISH causes an immediate new scan from IDLE the next cycle.
- x0/y0 changes during a scan have no effect, because the inputs are latched.
- Coordinate arithmetic is 11-bit modulo 2048. Termination uses offsets dx/dy, so a square crossing the 2047 boundary wraps addresses but still issues exactly (SIZE+1)^2 reads.
- Reset mid-scan or mid-drain: next cycle IDLE with all outputs at reset values. In-flight returns are discarded.

Optional Feature:
SQUARE_SAMPLER_EARLY_EXIT_EN
- Defined: in SCAN, the first delayed-valid rd_data=1 stops new requests the same cycle (rd_en=0) -> DRAIN. Returns from requests already in flight are counted. count then means "at least 1 + in-flight lit", and hit=1. done latency shrinks accordingly.
- Undefined: full scan always, exact count as above.

Decomposition:
- Package square_pkg: COORD_W=11 localparam, state enum type {IDLE, SCAN, DRAIN, FINISH}, shared with the drawer.
- Natural sub-module: square_scan_counter. It holds the dx/dy offset counter with load/step inputs and a last output. The drawer can later reuse it.
- The return pipeline and accumulator stay inline.

Test Plan:
- Reset mid-SCAN (SIZE=2, third rd_en cycle) -> next cycle rd_en=0, busy=0, count=0, done=0. A following start runs a clean 9-read scan.
- SIZE=2, RD_LAT=1, empty framebuffer, x0=20, y0=20, start one cycle -> 9 rd_en cycles. Coordinates (20,20),(21,20),(22,20),(20,21)..(22,22) in order. done 11 cycles after first rd_en; count=0, hit=0.
- Same square, model lights (21,21) and (22,22) -> count=2, hit=1. Then a new scan at x0=0, y0=0 (unlit) -> count stays 2 until its done, then 0.
- RD_LAT=3, all pixels lit, SIZE=2 -> count=9. done 13 cycles after first rd_en.
- start pulsed during SCAN and DRAIN -> ignored, single done.
- x0=2046, SIZE=2 -> rd_x sequence 2046,2047,0 per row, 9 reads, done normal.
- With SQUARE_SAMPLER_EARLY_EXIT_EN, lit at (20,20), RD_LAT=1 -> exactly 2 rd_en cycles, then done with hit=1.
